// File: rtl/proc_bus_pkg.sv
// Shared address-map constants for the processor memory/IO bridge.
// Pure definitions: no latency and no backpressure.
package proc_bus_pkg;

  typedef logic [3:0] region_t;
  typedef logic [1:0] tmr_off_t;

  localparam region_t REG_RAM = 4'h0;
  localparam region_t REG_LED = 4'h1;
  localparam region_t REG_SW  = 4'h3;
  localparam region_t REG_TMR = 4'h5;

  localparam tmr_off_t TMR_RELOAD = 2'd0;
  localparam tmr_off_t TMR_COUNT  = 2'd1;
  localparam tmr_off_t TMR_STATUS = 2'd2;

  typedef struct packed {
    logic run;
    logic expired;
  } tmr_status_t;

  function automatic region_t region_of(input logic [15:0] a);
    return a[15:12];
  endfunction

endpackage

// File: rtl/io_timer.sv
// Auto-reloading down-counter with a sticky expiry flag; state updates on the edge.
// No backpressure: writes and clears are accepted every cycle.
module io_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_reload,
  input  logic        clr_expired,
  input  logic [15:0] wdata,
  output logic [15:0] reload,
  output logic [15:0] count,
  output logic        run,
  output logic        expired
);

  logic [15:0] reload_q, reload_d;
  logic [15:0] count_q, count_d;
  logic        run_q, run_d;
  logic        expired_q, expired_d;

  always_comb begin
    reload_d  = reload_q;
    count_d   = count_q;
    run_d     = run_q;
    expired_d = expired_q;

    // Clear is applied before the expiry set so a same-cycle expiry wins.
    if (clr_expired) begin
      expired_d = 1'b0;
    end

    if (run_q) begin
      if (count_q == 16'd1) begin
        count_d   = reload_q;
        expired_d = 1'b1;
      end else begin
        count_d = count_q - 16'd1;
      end
    end

    // A reload write overrides everything, including a same-cycle expiry.
    if (wr_reload) begin
      reload_d  = wdata;
      count_d   = wdata;
      run_d     = (wdata != 16'd0);
      expired_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reload_q  <= 16'd0;
      count_q   <= 16'd0;
      run_q     <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      reload_q  <= reload_d;
      count_q   <= count_d;
      run_q     <= run_d;
      expired_q <= expired_d;
    end
  end

  assign reload  = reload_q;
  assign count   = count_q;
  assign run     = run_q;
  assign expired = expired_q;

endmodule

// File: rtl/proc_mem_io_bridge.sv
// Decodes processor addresses into RAM, LEDs, synchronised switches and a timer.
// Read data returns exactly 1 cycle after the address; no backpressure, writes take effect every w edge.
module proc_mem_io_bridge
  import proc_bus_pkg::*;
#(
  parameter int RAM_AW = 8,
  parameter int LED_W  = 10,
  parameter int SW_W   = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       addr,
  input  logic [15:0]       dout,
  input  logic              w,
  output logic [15:0]       din,
  output logic [RAM_AW-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              mem_we,
  input  logic [15:0]       mem_rdata,
  input  logic [SW_W-1:0]   sw,
  output logic [LED_W-1:0]  led,
  output logic              timer_irq
);

  region_t  region;
  tmr_off_t tmr_off;
  logic     sel_tmr;

  logic [LED_W-1:0] led_q, led_d;
  logic [SW_W-1:0]  sw_meta_q, sw_sync_q;
  region_t          sel_q, sel_d;
  logic [15:0]      per_q, per_d;

  logic        tmr_wr_reload;
  logic        tmr_clr;
  logic [15:0] tmr_reload;
  logic [15:0] tmr_count;
  tmr_status_t tmr_status;

  logic unused_addr_bits;

  assign region  = region_of(addr);
  assign tmr_off = addr[1:0];
  assign sel_tmr = (region == REG_TMR);

  assign unused_addr_bits = ^addr[11:2];

  assign mem_addr  = addr[RAM_AW-1:0];
  assign mem_wdata = dout;
  assign mem_we    = w & (region == REG_RAM);

  assign tmr_wr_reload = w & sel_tmr & (tmr_off == TMR_RELOAD);
  assign tmr_clr       = w & sel_tmr & (tmr_off == TMR_STATUS) & dout[0];

  io_timer u_timer (
    .clk         (clk),
    .rst         (reset),
    .wr_reload   (tmr_wr_reload),
    .clr_expired (tmr_clr),
    .wdata       (dout),
    .reload      (tmr_reload),
    .count       (tmr_count),
    .run         (tmr_status.run),
    .expired     (tmr_status.expired)
  );

  always_comb begin
    led_d = led_q;
    if (w && (region == REG_LED)) begin
      led_d = dout[LED_W-1:0];
    end
  end

  // Peripheral word is sampled from current state so a write on the previous
  // edge is already visible to a back-to-back read.
  always_comb begin
    sel_d = region;
    per_d = 16'd0;
    unique case (region)
      REG_LED: per_d[LED_W-1:0] = led_q;
      REG_SW:  per_d[SW_W-1:0]  = sw_sync_q;
      REG_TMR: begin
        unique case (tmr_off)
          TMR_RELOAD: per_d = tmr_reload;
          TMR_COUNT:  per_d = tmr_count;
          TMR_STATUS: per_d = {14'd0, tmr_status};
          default:    per_d = 16'd0;
        endcase
      end
      default: per_d = 16'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q     <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      sel_q     <= REG_RAM;
      per_q     <= 16'd0;
    end else begin
      led_q     <= led_d;
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
      sel_q     <= sel_d;
      per_q     <= per_d;
    end
  end

  assign din       = (sel_q == REG_RAM) ? mem_rdata : per_q;
  assign led       = led_q;
  assign timer_irq = tmr_status.expired;

endmodule

// File: tb/tb_proc_mem_io_bridge.sv
// Directed bench for proc_mem_io_bridge with a behavioural synchronous RAM.
module tb_proc_mem_io_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] addr = 16'h0000;
  logic [15:0] dout = 16'h0000;
  logic        w = 1'b0;
  logic [15:0] din;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic [15:0] mem_rdata;
  logic [9:0]  sw = 10'h000;
  logic [9:0]  led;
  logic        timer_irq;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] ram [0:255];
  logic [15:0] ram_rd_q = 16'h0000;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    ram_rd_q <= ram[mem_addr];
  end
  assign mem_rdata = ram_rd_q;

  proc_mem_io_bridge #(.RAM_AW(8), .LED_W(10), .SW_W(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .addr      (addr),
    .dout      (dout),
    .w         (w),
    .din       (din),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .sw        (sw),
    .led       (led),
    .timer_irq (timer_irq)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] d, input logic wr);
    addr = a;
    dout = d;
    w    = wr;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 16'h0000;
    ram[8'h00] = 16'h5A5A;
    ram[8'h12] = 16'hBEEF;

    // Reset state
    #1;
    check("rst_led", {6'd0, led}, 16'h0000);
    check("rst_irq", {15'd0, timer_irq}, 16'h0000);
    check("rst_mem_we", {15'd0, mem_we}, 16'h0000);
    step();
    step();
    check("rst_din_ram", din, 16'h5A5A);
    reset = 1'b0;

    // LED write then immediate read-back
    drive(16'h1000, 16'h03A5, 1'b1);
    step();
    check("led_write", {6'd0, led}, 16'h03A5);
    drive(16'h1000, 16'h0000, 1'b0);
    step();
    check("led_readback", din, 16'h03A5);

    // RAM read and write
    drive(16'h0012, 16'h0000, 1'b0);
    step();
    check("ram_read", din, 16'hBEEF);
    drive(16'h0034, 16'h1234, 1'b1);
    #1;
    check("ram_we", {15'd0, mem_we}, 16'h0001);
    check("ram_waddr", {8'd0, mem_addr}, 16'h0034);
    check("ram_wdata", mem_wdata, 16'h1234);
    step();
    drive(16'h0034, 16'h0000, 1'b0);
    #1;
    check("ram_we_off", {15'd0, mem_we}, 16'h0000);
    step();
    check("ram_readback", din, 16'h1234);

    // Switch synchroniser latency
    drive(16'h3000, 16'h0000, 1'b0);
    sw = 10'h2AA;
    step();
    check("sw_edge1", din, 16'h0000);
    step();
    check("sw_edge2", din, 16'h0000);
    step();
    check("sw_edge3", din, 16'h02AA);

    // Unmapped region
    drive(16'h7000, 16'hFFFF, 1'b1);
    #1;
    check("unmapped_we", {15'd0, mem_we}, 16'h0000);
    step();
    check("unmapped_led", {6'd0, led}, 16'h03A5);
    drive(16'h7000, 16'h0000, 1'b0);
    step();
    check("unmapped_read", din, 16'h0000);

    // Timer countdown with auto-reload
    drive(16'h5000, 16'h0003, 1'b1);
    step();
    drive(16'h5001, 16'h0000, 1'b0);
    step();
    check("tmr_cnt3", din, 16'h0003);
    step();
    check("tmr_cnt2", din, 16'h0002);
    step();
    check("tmr_cnt1", din, 16'h0001);
    check("tmr_irq_set", {15'd0, timer_irq}, 16'h0001);
    step();
    check("tmr_reload3", din, 16'h0003);
    check("tmr_irq_hold", {15'd0, timer_irq}, 16'h0001);
    drive(16'h5002, 16'h0001, 1'b1);
    step();
    check("tmr_clear", {15'd0, timer_irq}, 16'h0000);

    // Count is now 1: this reload write collides with expiry
    drive(16'h5000, 16'h0002, 1'b1);
    step();
    check("coll_reload_irq", {15'd0, timer_irq}, 16'h0000);
    drive(16'h5001, 16'h0000, 1'b0);
    step();
    check("coll_reload_cnt", din, 16'h0002);
    step();
    check("tmr2_cnt1", din, 16'h0001);
    check("tmr2_irq", {15'd0, timer_irq}, 16'h0001);
    step();
    check("tmr2_cnt2", din, 16'h0002);
    // Count is 1 again: status clear collides with expiry
    drive(16'h5002, 16'h0001, 1'b1);
    step();
    check("coll_clear_irq", {15'd0, timer_irq}, 16'h0001);
    drive(16'h5001, 16'h0000, 1'b0);
    step();
    check("coll_clear_cnt", din, 16'h0002);
    // Count is 1: reload write of 5 collides with expiry
    drive(16'h5000, 16'h0005, 1'b1);
    step();
    check("coll2_irq", {15'd0, timer_irq}, 16'h0000);
    drive(16'h5001, 16'h0000, 1'b0);
    step();
    check("coll2_cnt5", din, 16'h0005);
    step();
    check("coll2_cnt4", din, 16'h0004);
    drive(16'h5002, 16'h0000, 1'b0);
    step();
    check("status_run", din, 16'h0002);
    drive(16'h5000, 16'h0000, 1'b0);
    step();
    check("reload_read", din, 16'h0005);
    drive(16'h5001, 16'h0000, 1'b0);
    repeat (3) step();
    check("pre_rst_irq", {15'd0, timer_irq}, 16'h0001);

    // Asynchronous reset between edges
    #3;
    reset = 1'b1;
    #1;
    check("arst_led", {6'd0, led}, 16'h0000);
    check("arst_irq", {15'd0, timer_irq}, 16'h0000);
    check("arst_din", din, ram_rd_q);
    @(negedge clk);
    reset = 1'b0;
    step();
    check("post_rst_cnt", din, 16'h0000);
    step();
    check("post_rst_hold", din, 16'h0000);
    drive(16'h5002, 16'h0000, 1'b0);
    step();
    check("post_rst_status", din, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/proc_mem_io_bridge.md
Name: proc_mem_io_bridge

Overview:
- Sits directly downstream of the processor's ADDR/DOUT/W outputs, which the control FSM drives via ADDR_in, DOUT_in and W_inp.
- Decodes the 16-bit address into synchronous RAM, an LED register, synchronised switches and a down-counting timer.
- Returns read data on `din` with exactly one cycle of latency. This matches the FSM's T0 address / T1 wait / T2 capture timing.

Parameters:
- RAM_AW, 8, RAM word-address width; RAM occupies 0x0000..(2^RAM_AW - 1).
- LED_W, 10, LED register width.
- SW_W, 10, switch input width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- addr  in  16  processor address-register output.
- dout  in  16  processor data-out register output.
- w  in  1  processor write strobe; a write occurs on every clk edge where w=1.
- din  out  16  read data to the processor; valid 1 cycle after `addr` is presented.
- mem_addr  out  RAM_AW  synchronous RAM address, driven combinationally as addr[RAM_AW-1:0].
- mem_wdata  out  16  RAM write data, equal to dout.
- mem_we  out  1  RAM write enable.
- mem_rdata  in  16  synchronous RAM read data, registered inside the RAM with 1-cycle latency.
- sw  in  SW_W  asynchronous slide switches.
- led  out  LED_W  LED register.
- timer_irq  out  1  timer expired flag, level and sticky.

Behaviour:
- Address decode on addr[15:12]:
  - 0x0 = RAM.
  - 0x1 = LED register.
  - 0x3 = switches, read-only.
  - 0x5 = timer: addr[1:0]=0 RELOAD, 1 COUNT, 2 STATUS.
  - Any other region: reads return 0x0000, writes are ignored.
- Writes (w=1):
  - mem_we = w & (region==0x0).
  - LED: led <= dout[LED_W-1:0].
  - RELOAD: reload <= dout, count <= dout, run <= (dout!=0), expired <= 0.
  - STATUS: if dout[0]=1, expired <= 0.
  - COUNT: write ignored.
- Reads:
  - A registered select sel_q <= region is captured every cycle.
  - A registered peripheral word per_q is captured every cycle:
    - switches = zero-extended sw_sync.
    - RELOAD = reload.
    - COUNT = count.
    - STATUS = {14'b0, run, expired}.
  - din = (sel_q==RAM) ? mem_rdata : per_q.
  - Latency is exactly 1 cycle for every region. Reads have no side effects.
- Switch sync: 2-FF synchroniser. A change on sw is visible to a read issued 2 edges later, at the earliest.
- Timer, evaluated each edge while run=1:
  - If count==1: count <= reload, expired <= 1, run stays 1 (auto-reload).
  - Otherwise: count <= count-1.
  - If run=0, count holds.
  - timer_irq = expired.
- Simultaneous events:
  - A RELOAD write in the same cycle as expiry: the write wins and expired ends 0.
  - A STATUS clear in the same cycle as expiry: the set wins and expired ends 1.
- Reset (asynchronous, any time, including mid-read):
  - led=0, reload=0, count=0, run=0, expired=0, sw_sync=0, sel_q=RAM region, per_q=0.
  - din therefore equals mem_rdata immediately after reset.
  - timer_irq=0, mem_we=0 (w-qualified).
- Back-to-back accesses: a write followed immediately by a read of the same peripheral address returns the new value on the read's din cycle.

Decomposition:
- Shared package proc_bus_pkg holds:
  - region codes: REG_RAM=4'h0, REG_LED=4'h1, REG_SW=4'h3, REG_TMR=4'h5;
  - timer offsets: TMR_RELOAD=2'd0, TMR_COUNT=2'd1, TMR_STATUS=2'd2.
- One sub-module is natural: io_timer, which contains reload/count/run/expired and the write and clear ports. Decode, LEDs, the synchroniser and the read-mux pipeline stay in the bridge.

Test Plan:
- After reset, write addr=0x1000 dout=0x03A5 w=1 -> led=0x3A5 after the edge; read 0x1000 -> din=0x03A5 exactly one cycle later.
- RAM model preloaded [0x12]=0xBEEF; present addr=0x0012 -> din=0xBEEF in the next cycle; write 0x0034=0x1234 -> mem_we=1 for one cycle with mem_addr=0x34 and mem_wdata=0x1234.
- sw=0x2AA held stable; read 0x3000 -> din=0x02AA once the 2-FF delay has passed; read 0x7000 -> din=0x0000.
- Write RELOAD 0x5000=3 -> COUNT reads 3,2,1 on successive cycles, then 3 again with timer_irq=1; write STATUS 0x5002=1 -> timer_irq=0.
- Force the STATUS clear write into the expiry cycle -> timer_irq stays 1; force a RELOAD write into the expiry cycle -> timer_irq=0 and count=new value.
- Assert reset asynchronously mid-countdown, between clock edges -> led, timer_irq and STATUS go to 0 immediately; after release, COUNT reads 0 and does not decrement.
